pipelined_adder: RTL and testbench

//   Parametrised, pipelined N-bit adder/subtractor with a valid/ready handshake.
//   The carry chain is split into STAGES equal chunks, with one chunk per register

---
 rtl/pipelined_adder.sv | 134 +++++++++++++
 tb/tb_pipelined_adder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Pipelined N-bit adder/subtractor with a valid/ready handshake.
// The carry chain is cut into STAGES equal chunks, one chunk per register stage.
// Each stage register holds a mixed word: completed sum bits below the chunk
// boundary and untouched operand-A bits above it. Operand B' travels in skew
// registers alongside. The whole pipe advances together under a global stall.
module pipelined_adder #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] termA,
  input  logic [N-1:0] termB,
  input  logic         carry_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         carry,
  output logic         overflow
);

  localparam int W  = N / STAGES;
  // Number of B' skew registers between stages (at least one entry so the
  // array stays legal when STAGES is 1).
  localparam int NB = (STAGES > 1) ? (STAGES - 1) : 1;

  // Refuse to elaborate when the width cannot be split into equal chunks.
  if ((STAGES < 1) || ((N % STAGES) != 0)) begin : g_bad_params
    $error("pipelined_adder: N must be a multiple of STAGES and STAGES >= 1");
  end

  // Stage registers.
  logic [N-1:0] data_r  [STAGES];  // sum bits below the boundary, A bits above
  logic [N-1:0] b_r     [NB];      // inverted-or-not operand B for later chunks
  logic         cy_r    [STAGES];  // carry out of the chunk just completed
  logic         vld_r   [STAGES];  // stage holds a live operation
  logic         ovf_r;             // signed overflow of the finished result

  // Per-stage inputs, either from the ports (stage 0) or the previous stage.
  logic [N-1:0] a_in    [STAGES];
  logic [N-1:0] b_in    [STAGES];
  logic         c_in    [STAGES];
  logic         v_in    [STAGES];

  logic advance;

  // A global stall: the pipe only moves when the output slot is free or draining.
  assign advance   = !vld_r[STAGES-1] || out_ready;
  assign in_ready  = advance;

  assign out_valid = vld_r[STAGES-1];
  assign sum       = data_r[STAGES-1];
  assign carry     = cy_r[STAGES-1];
  assign overflow  = ovf_r;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [W:0]   part;
    logic [N-1:0] next_data;

    if (k == 0) begin : g_first
      // Subtraction is A + ~B + ~borrow, so invert B and the carry-in here.
      assign a_in[k] = termA;
      assign b_in[k] = sub ? ~termB : termB;
      assign c_in[k] = carry_in ^ sub;
      assign v_in[k] = in_valid;
    end else begin : g_next
      assign a_in[k] = data_r[k-1];
      assign b_in[k] = b_r[k-1];
      assign c_in[k] = cy_r[k-1];
      assign v_in[k] = vld_r[k-1];
    end

    // One W-bit slice of the carry chain, with its carry out in the top bit.
    assign part = {1'b0, a_in[k][k*W +: W]} + {1'b0, b_in[k][k*W +: W]}
                + {{W{1'b0}}, c_in[k]};

    // Replace this stage's chunk of the mixed word with the finished sum bits.
    always_comb begin
      next_data             = a_in[k];
      next_data[k*W +: W]   = part[W-1:0];
    end

    // Stage state: valid always follows the pipe, data only loads for live ops
    // so the output keeps its last value across bubbles.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_r[k]  <= 1'b0;
        data_r[k] <= '0;
        cy_r[k]   <= 1'b0;
      end else if (advance) begin
        vld_r[k] <= v_in[k];
        if (v_in[k]) begin
          data_r[k] <= next_data;
          cy_r[k]   <= part[W];
        end else begin
          data_r[k] <= data_r[k];
          cy_r[k]   <= cy_r[k];
        end
      end else begin
        vld_r[k]  <= vld_r[k];
        data_r[k] <= data_r[k];
        cy_r[k]   <= cy_r[k];
      end
    end

    if (k < STAGES - 1) begin : g_skew
      // Carry operand B' forward for the chunks still to be added.
      always_ff @(posedge clk) begin
        if (rst) begin
          b_r[k] <= '0;
        end else if (advance && v_in[k]) begin
          b_r[k] <= b_in[k];
        end else begin
          b_r[k] <= b_r[k];
        end
      end
    end else begin : g_ovf
      // Carry into the MSB is a^b^s at bit N-1; overflow is that XOR carry out.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (advance && v_in[k]) begin
          ovf_r <= a_in[k][N-1] ^ b_in[k][N-1] ^ part[W-1] ^ part[W];
        end else begin
          ovf_r <= ovf_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (N=8, STAGES=2): directed table,
// backpressure and reset sequences, a strided operand sweep and a random
// handshake run, all against an arithmetic reference model and an in-order queue.
module tb_pipelined_adder;

  localparam int N      = 8;
  localparam int STAGES = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] termA;
  logic [N-1:0] termB;
  logic         carry_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         carry;
  logic         overflow;

  pipelined_adder #(.N(N), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .termA(termA), .termB(termB), .carry_in(carry_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sb;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec_t;

  vec_t       tbl [9];
  logic [9:0] exp_q [$];   // {overflow, carry, sum} in acceptance order
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_acc = 0;
  int         n_ret = 0;
  logic       sb_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic cin, input logic sb);
    int ua, ub, sa, sbv, ci, r, sr;
    logic c, o;
    ua = int'(a); ub = int'(b); ci = int'(cin);
    sa = int'($signed(a)); sbv = int'($signed(b));
    if (!sb) begin
      r  = ua + ub + ci;
      c  = (r > 255);
      sr = sa + sbv + ci;
    end else begin
      r  = ua - ub - ci;
      c  = (r >= 0);
      sr = sa - sbv - ci;
    end
    o = (sr > 127) || (sr < -128);
    return {o, c, 8'(r & 255)};
  endfunction

  // One clock: observe handshakes at the falling edge, then pass the rising edge.
  task automatic tick();
    logic [9:0] e;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
    end else if (sb_en) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_result", {22'd0, overflow, carry, sum}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sb_result", {22'd0, overflow, carry, sum}, {22'd0, e});
          n_ret++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(termA, termB, carry_in, sub));
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sb);
    in_valid = 1'b1; termA = a; termB = b; carry_in = cin; sub = sb;
  endtask

  initial begin
    int base, cyc;
    logic [9:0] m;

    tbl[0] = '{8'd200, 8'd100, 1'b0, 1'b0, 8'd44,  1'b1, 1'b0};
    tbl[1] = '{8'h0F,  8'h01,  1'b0, 1'b0, 8'h10,  1'b0, 1'b0};
    tbl[2] = '{8'd127, 8'd1,   1'b0, 1'b0, 8'd128, 1'b0, 1'b1};
    tbl[3] = '{8'hFF,  8'h00,  1'b1, 1'b0, 8'h00,  1'b1, 1'b0};
    tbl[4] = '{8'd5,   8'd7,   1'b0, 1'b1, 8'hFE,  1'b0, 1'b0};
    tbl[5] = '{8'd7,   8'd5,   1'b1, 1'b1, 8'h01,  1'b1, 1'b0};
    tbl[6] = '{8'h80,  8'h01,  1'b0, 1'b1, 8'h7F,  1'b1, 1'b1};
    tbl[7] = '{8'hFF,  8'hFF,  1'b1, 1'b0, 8'hFF,  1'b1, 1'b0};
    tbl[8] = '{8'h80,  8'h80,  1'b0, 1'b0, 8'h00,  1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; termA = '0; termB = '0;
    carry_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state.
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_carry", {31'd0, carry}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed vectors, each checked at exactly STAGES cycles of latency.
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sb);
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_not_early", i), {31'd0, out_valid}, 32'd0);
      tick();
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_result", i), {22'd0, overflow, carry, sum},
          {22'd0, tbl[i].o, tbl[i].c, tbl[i].s});
      tick();
    end

    // Output holds its last value across bubbles.
    tick();
    chk("bubble_hold_sum", {24'd0, sum}, {24'd0, tbl[8].s});

    sb_en = 1'b1;

    // Backpressure: fill the pipe, stall 5 cycles, release.
    out_ready = 1'b0;
    base = n_ret;
    drive(8'd1, 8'd10, 1'b0, 1'b0); tick();
    drive(8'd2, 8'd10, 1'b0, 1'b0); tick();
    drive(8'd3, 8'd10, 1'b0, 1'b0);
    m = model(8'd1, 8'd10, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_hold", {22'd0, overflow, carry, sum}, {22'd0, m});
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while ((n_ret - base) < 3 && cyc < 10) begin tick(); cyc++; end
    tick();
    chk("stall_release_count", n_ret - base, 32'd3);
    chk("stall_queue_empty", exp_q.size(), 32'd0);

    // Reset with two operations in flight.
    drive(8'd50, 8'd60, 1'b0, 1'b0); tick();
    drive(8'd70, 8'd80, 1'b0, 1'b1); tick();
    in_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    chk("inflight_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("inflight_rst_result", {22'd0, overflow, carry, sum}, 32'd0);
    drive(8'd9, 8'd4, 1'b0, 1'b0); tick();
    in_valid = 1'b0;
    chk("post_rst_not_early", {31'd0, out_valid}, 32'd0);
    tick();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_sum", {24'd0, sum}, 32'd13);
    tick(); tick();
    chk("post_rst_no_ghosts", exp_q.size(), 32'd0);

    // Strided operand sweep, back to back: every a, 16 b values, both modes.
    base = n_ret;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b += 17) begin
        drive(8'(a), 8'(b), 1'(b & 1), 1'((a >> 3) & 1));
        chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
      end
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("stream_count", n_ret - base, 32'd4096);

    // Random valid/ready with scoreboarded results.
    base = n_acc;
    cyc  = 0;
    while (((n_acc - base) < 3000 || exp_q.size() != 0) && cyc < 30000) begin
      if ((n_acc - base) < 3000 && $urandom_range(9, 0) < 7) begin
        drive(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(9, 0) < 7);
      tick();
      cyc++;
    end
    chk("random_accepted", n_acc - base, 32'd3000);
    chk("random_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
